// File: rtl/alu_ex_stage.sv
// Purpose: MIPS execute stage; ALU result plus flags held in the EX/MEM valid/ready register.
// Latency: one cycle from accept to out_valid; a simultaneous drain and accept sustain full throughput.
// Backpressure: in_ready = ~out_valid | out_ready; a stalled result holds every output stable.
module alu_ex_stage #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ctl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         shamt,
    input  logic               use_shamt,
    input  logic               trap_ovf,
    input  logic [REGADDR-1:0] rd,
    input  logic               reg_write,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [REGADDR-1:0] out_rd,
    output logic               out_reg_write,
    output logic               out_zero,
    output logic               out_ovf,
    output logic               out_illegal
);

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_XOR  = 4'b0011;
    localparam logic [3:0] CTL_NOR  = 4'b0100;
    localparam logic [3:0] CTL_SLTU = 4'b0101;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_SLL  = 4'b1000;
    localparam logic [3:0] CTL_SRL  = 4'b1001;
    localparam logic [3:0] CTL_SRA  = 4'b1011;

    typedef struct packed {
        logic [WIDTH-1:0]   result;
        logic [REGADDR-1:0] rd;
        logic               reg_write;
        logic               zero;
        logic               ovf;
        logic               illegal;
    } ex_t;

    ex_t              nxt;
    ex_t              q;
    logic             vld;
    logic [4:0]       sh;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             illegal;
    logic             ovf;
    logic             accept;

    assign sh   = use_shamt ? shamt : a[4:0];
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        res     = '0;
        illegal = 1'b0;
        ovf     = 1'b0;
        case (ctl)
            CTL_AND:  res = a & b;
            CTL_OR:   res = a | b;
            CTL_ADD: begin
                res = sum;
                ovf = trap_ovf & (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
            end
            CTL_XOR:  res = a ^ b;
            CTL_NOR:  res = ~(a | b);
            CTL_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            CTL_SUB: begin
                res = diff;
                ovf = trap_ovf & (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
            end
            CTL_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CTL_SLL:  res = b << sh;
            CTL_SRL:  res = b >> sh;
            CTL_SRA:  res = $signed(b) >>> sh;
            default:  illegal = 1'b1;
        endcase
    end

    // Result is latched even when the write is suppressed, for debug visibility.
    always_comb begin
        nxt.result    = res;
        nxt.rd        = rd;
        nxt.reg_write = reg_write & ~ovf & ~illegal;
        nxt.zero      = (res == '0);
        nxt.ovf       = ovf;
        nxt.illegal   = illegal;
    end

    assign in_ready = ~vld | out_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (flush) begin
            // Kill the held op and anything accepted this cycle; data fields keep last values.
            vld         <= 1'b0;
            q.reg_write <= 1'b0;
            q.ovf       <= 1'b0;
            q.illegal   <= 1'b0;
        end else if (accept) begin
            q   <= nxt;
            vld <= 1'b1;
        end else if (out_ready) begin
            vld <= 1'b0;
        end
    end

    assign out_valid     = vld;
    assign out_result    = q.result;
    assign out_rd        = q.rd;
    assign out_reg_write = q.reg_write;
    assign out_zero      = q.zero;
    assign out_ovf       = q.ovf;
    assign out_illegal   = q.illegal;

endmodule
